// File: rtl/int_ctxt_stack_nested_pkg.sv
// -----------------------------------------------------------------------------
// int_ctxt_pkg
// Shared definitions for the nested interrupt context stack:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - packed context width and field offsets for packing/unpacking
// Packed context layout, MSB to LSB:
//   { ret_addr, ctxt_addr, tmp_bit_cnt, tmp_pass, tmp_mask, tmp_C_F }
// -----------------------------------------------------------------------------
package int_ctxt_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PUSH = 2'd1;
   localparam logic [1:0] ST_POP  = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam int PASS_W = 3;

   // CTXT_W = 2*ADDR_WIDTH_MEM + 2*DATA_WIDTH + 3 + DATA_DEPTH
   function automatic int ctxt_w(input int aw, input int dw, input int dd);
      return 2*aw + 2*dw + PASS_W + dd;
   endfunction

   function automatic int off_cf(input int aw, input int dw, input int dd);
      return 0;
   endfunction

   function automatic int off_mask(input int aw, input int dw, input int dd);
      return dd;
   endfunction

   function automatic int off_pass(input int aw, input int dw, input int dd);
      return dd + dw;
   endfunction

   function automatic int off_bit_cnt(input int aw, input int dw, input int dd);
      return dd + dw + PASS_W;
   endfunction

   function automatic int off_ctxt_addr(input int aw, input int dw, input int dd);
      return dd + 2*dw + PASS_W;
   endfunction

   function automatic int off_ret_addr(input int aw, input int dw, input int dd);
      return aw + dd + 2*dw + PASS_W;
   endfunction

endpackage

// File: rtl/int_ctxt_stack_nested_if.sv
// -----------------------------------------------------------------------------
// int_ctxt_stack_nested_if
// Bus between AP_ctrl (master) and the context stack (slave).
//   master drives : int_set, ret_valid, ret_addr, ctxt_addr, tmp_bit_cnt,
//                   tmp_pass, tmp_mask, tmp_C_F, err_clr
//   slave drives  : ctxt_rdy, push_done, *_ret, stack_cnt, full, empty,
//                   ovf_err, udf_err, state_dbg
// Handshake: int_set / ret_valid are level requests whose rising edge means
// one operation. The master holds the push fields stable from the int_set
// rise until push_done pulses; push_done and ctxt_rdy are single-cycle
// completion pulses and *_ret are valid from the ctxt_rdy cycle onward.
// -----------------------------------------------------------------------------
interface int_ctxt_stack_nested_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int DATA_DEPTH     = 128,
   parameter int ADDR_WIDTH_MEM = 16,
   parameter int STACK_DEPTH    = 8,
   parameter int CNT_WIDTH      = $clog2(STACK_DEPTH+1)
);
   logic                      int_set;
   logic                      ret_valid;
   logic [ADDR_WIDTH_MEM-1:0] ret_addr;
   logic [ADDR_WIDTH_MEM-1:0] ctxt_addr;
   logic [DATA_WIDTH-1:0]     tmp_bit_cnt;
   logic [2:0]                tmp_pass;
   logic [DATA_WIDTH-1:0]     tmp_mask;
   logic [DATA_DEPTH-1:0]     tmp_C_F;
   logic                      err_clr;

   logic                      ctxt_rdy;
   logic                      push_done;
   logic [ADDR_WIDTH_MEM-1:0] ret_addr_ret;
   logic [ADDR_WIDTH_MEM-1:0] ctxt_addr_ret;
   logic [DATA_WIDTH-1:0]     tmp_bit_cnt_ret;
   logic [DATA_WIDTH-1:0]     tmp_mask_ret;
   logic [2:0]                tmp_pass_ret;
   logic [DATA_DEPTH-1:0]     tmp_C_F_ret;
   logic [CNT_WIDTH-1:0]      stack_cnt;
   logic                      full;
   logic                      empty;
   logic                      ovf_err;
   logic                      udf_err;
   logic [1:0]                state_dbg;

   modport master (
      output int_set, ret_valid, ret_addr, ctxt_addr, tmp_bit_cnt,
             tmp_pass, tmp_mask, tmp_C_F, err_clr,
      input  ctxt_rdy, push_done, ret_addr_ret, ctxt_addr_ret,
             tmp_bit_cnt_ret, tmp_mask_ret, tmp_pass_ret, tmp_C_F_ret,
             stack_cnt, full, empty, ovf_err, udf_err, state_dbg
   );

   modport slave (
      input  int_set, ret_valid, ret_addr, ctxt_addr, tmp_bit_cnt,
             tmp_pass, tmp_mask, tmp_C_F, err_clr,
      output ctxt_rdy, push_done, ret_addr_ret, ctxt_addr_ret,
             tmp_bit_cnt_ret, tmp_mask_ret, tmp_pass_ret, tmp_C_F_ret,
             stack_cnt, full, empty, ovf_err, udf_err, state_dbg
   );
endinterface

// File: rtl/int_ctxt_stack_nested_mem.sv
// -----------------------------------------------------------------------------
// ctxt_stack_mem
// DEPTH x WIDTH register array holding the packed contexts.
//   clk, rst        : clock; rst clears only the read-data register
//   wr_en/addr/data : synchronous write port
//   rd_en/addr      : synchronous read port
//   rd_data         : registered read data, holds until the next rd_en
// Array contents are deliberately not reset.
// -----------------------------------------------------------------------------
module ctxt_stack_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/int_ctxt_stack_nested.sv
// -----------------------------------------------------------------------------
// int_ctxt_stack_nested
// LIFO context stack for nested interrupts in the AP controller.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : int_ctxt_stack_nested_if.slave
//         requests  int_set (push), ret_valid (pop), err_clr
//         push data ret_addr, ctxt_addr, tmp_bit_cnt, tmp_pass, tmp_mask, tmp_C_F
//         results   ctxt_rdy, push_done, *_ret, stack_cnt, full, empty,
//                   ovf_err, udf_err, state_dbg
// Rising edges of int_set/ret_valid are latched into pend flags so requests
// arriving while busy are not lost. Push wins when both are ready in IDLE.
// -----------------------------------------------------------------------------
module int_ctxt_stack_nested
   import int_ctxt_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int DATA_DEPTH     = 128,
   parameter int ADDR_WIDTH_MEM = 16,
   parameter int STACK_DEPTH    = 8,
   parameter int CNT_WIDTH      = $clog2(STACK_DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   int_ctxt_stack_nested_if.slave bus
);
   localparam int CTXT_W   = ctxt_w(ADDR_WIDTH_MEM, DATA_WIDTH, DATA_DEPTH);
   localparam int IDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int O_CF     = off_cf(ADDR_WIDTH_MEM, DATA_WIDTH, DATA_DEPTH);
   localparam int O_MASK   = off_mask(ADDR_WIDTH_MEM, DATA_WIDTH, DATA_DEPTH);
   localparam int O_PASS   = off_pass(ADDR_WIDTH_MEM, DATA_WIDTH, DATA_DEPTH);
   localparam int O_BITCNT = off_bit_cnt(ADDR_WIDTH_MEM, DATA_WIDTH, DATA_DEPTH);
   localparam int O_CTXT   = off_ctxt_addr(ADDR_WIDTH_MEM, DATA_WIDTH, DATA_DEPTH);
   localparam int O_RET    = off_ret_addr(ADDR_WIDTH_MEM, DATA_WIDTH, DATA_DEPTH);

   logic [1:0]           state, state_nxt;
   logic                 int_q, ret_q;
   logic                 push_pend, pop_pend;
   logic [CNT_WIDTH-1:0] stack_cnt;
   logic                 push_done_q;
   logic                 ovf_q, udf_q;

   logic                 push_edge, pop_edge;
   logic                 launch_push, launch_pop;
   logic                 full, empty;
   logic                 do_write, do_read;
   logic                 ovf_ev, udf_ev;
   logic [CTXT_W-1:0]    wr_data, rd_data;
   logic [IDX_W-1:0]     wr_addr, rd_addr;

   assign push_edge = bus.int_set & ~int_q;
   assign pop_edge  = bus.ret_valid & ~ret_q;

   assign full  = (stack_cnt == CNT_WIDTH'(STACK_DEPTH));
   assign empty = (stack_cnt == '0);

   assign launch_push = (state == ST_IDLE) && (push_pend || push_edge);
   assign launch_pop  = (state == ST_IDLE) && !launch_push && (pop_pend || pop_edge);

   // Memory strobes are gated by rst so a reset in the PUSH/POP cycle leaves
   // neither a partial write nor a changed read register behind.
   assign do_write = (state == ST_PUSH) && !full  && !rst;
   assign do_read  = (state == ST_POP)  && !empty && !rst;
   assign ovf_ev   = (state == ST_PUSH) && full;
   assign udf_ev   = (state == ST_POP)  && empty;

   assign wr_addr = IDX_W'(stack_cnt);
   assign rd_addr = IDX_W'(stack_cnt - CNT_WIDTH'(1));
   assign wr_data = {bus.ret_addr, bus.ctxt_addr, bus.tmp_bit_cnt,
                     bus.tmp_pass, bus.tmp_mask, bus.tmp_C_F};

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (launch_push)     state_nxt = ST_PUSH;
            else if (launch_pop) state_nxt = ST_POP;
         end
         ST_PUSH: state_nxt = ST_IDLE;
         ST_POP:  state_nxt = empty ? ST_IDLE : ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         // Edge registers load the current level so a request held high
         // across reset is not mistaken for a fresh rising edge.
         int_q       <= bus.int_set;
         ret_q       <= bus.ret_valid;
         push_pend   <= 1'b0;
         pop_pend    <= 1'b0;
         stack_cnt   <= '0;
         push_done_q <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         state       <= state_nxt;
         int_q       <= bus.int_set;
         ret_q       <= bus.ret_valid;
         push_pend   <= launch_push ? 1'b0 : (push_pend | push_edge);
         pop_pend    <= launch_pop  ? 1'b0 : (pop_pend  | pop_edge);
         if (do_write)     stack_cnt <= stack_cnt + CNT_WIDTH'(1);
         else if (do_read) stack_cnt <= stack_cnt - CNT_WIDTH'(1);
         push_done_q <= (state == ST_PUSH);
         // An error event outranks a simultaneous clear.
         if (ovf_ev)           ovf_q <= 1'b1;
         else if (bus.err_clr) ovf_q <= 1'b0;
         if (udf_ev)           udf_q <= 1'b1;
         else if (bus.err_clr) udf_q <= 1'b0;
      end
   end

   ctxt_stack_mem #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (CTXT_W),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (do_write),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (do_read),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign bus.ctxt_rdy        = (state == ST_RESP);
   assign bus.push_done       = push_done_q;
   assign bus.ret_addr_ret    = rd_data[O_RET    +: ADDR_WIDTH_MEM];
   assign bus.ctxt_addr_ret   = rd_data[O_CTXT   +: ADDR_WIDTH_MEM];
   assign bus.tmp_bit_cnt_ret = rd_data[O_BITCNT +: DATA_WIDTH];
   assign bus.tmp_pass_ret    = rd_data[O_PASS   +: PASS_W];
   assign bus.tmp_mask_ret    = rd_data[O_MASK   +: DATA_WIDTH];
   assign bus.tmp_C_F_ret     = rd_data[O_CF     +: DATA_DEPTH];
   assign bus.stack_cnt       = stack_cnt;
   assign bus.full            = full;
   assign bus.empty           = empty;
   assign bus.ovf_err         = ovf_q;
   assign bus.udf_err         = udf_q;
   assign bus.state_dbg       = state;
endmodule
